decode_stage_pv: RTL and testbench

- Parametrised next-generation instruction-decode stage for the scalar/vector pipeline, sitting between the fetch pipeline register and the execute stage.
- Contains the scalar register file (NREGS x DATA_W), the vector register file (NREGS x LANES*DATA_W), the control decoder and immediate extender.
- Adds a valid/ready handshake, flush, write-to-read bypass and load-use bubble insertion.
- Replaces the flat output bus with named, width-parametrised outputs.

---
 rtl/decode_pkg.sv | 43 ++++
 rtl/regfile_bypass.sv | 40 ++++
 rtl/decode_stage_pv.sv | 186 ++++++++++++++++++
 tb/tb_decode_stage_pv.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field positions, op classes and
// the packed execute-control word.
package decode_pkg;

  typedef enum logic [1:0] {
    ALU  = 2'b00,
    ALUI = 2'b01,
    MEM  = 2'b10,
    BR   = 2'b11
  } optype_e;

  localparam logic [3:0] LD   = 4'b0000;
  localparam logic [3:0] ST   = 4'b0001;
  localparam logic [3:0] ADDV = 4'b1101;
  localparam logic [3:0] MULV = 4'b1110;

  localparam int OPT_LSB = 30;
  localparam int OPC_LSB = 26;
  localparam int RC_LSB  = 22;
  localparam int RA_LSB  = 18;
  localparam int RB_LSB  = 14;
  localparam int FLD_W   = 4;
  localparam int IMMI_W  = 14;
  localparam int IMMB_W  = 22;

  // Bit order matches ex_ctrl, MSB first.
  typedef struct packed {
    logic [1:0] optype;
    logic [3:0] opcode;
    logic       imm_src;
    logic       branch;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_write_v;
  } ctrl_t;

  // Vector ALU ops occupy the top of the opcode space (ADDV, MULV, 1111).
  function automatic logic is_vec_op(input logic [3:0] opc);
    return opc >= ADDV;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// NREGS x W register file: three combinational read ports, one write port,
// write-to-read bypass, async clear.
module regfile_bypass #(
  parameter int W     = 24,
  parameter int NREGS = 16,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [RW-1:0] i_wa,
  input  logic [W-1:0]  i_wd,
  input  logic [RW-1:0] i_ra1,
  input  logic [RW-1:0] i_ra2,
  input  logic [RW-1:0] i_ra3,
  output logic [W-1:0]  o_rd1,
  output logic [W-1:0]  o_rd2,
  output logic [W-1:0]  o_rd3
);

  logic [NREGS-1:0][W-1:0] r_mem;
  logic [2:0][RW-1:0]      w_ra;
  logic [2:0][W-1:0]       w_rd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_mem       <= '0;
    else if (i_we) r_mem[i_wa] <= i_wd;
  end

  assign w_ra = {i_ra3, i_ra2, i_ra1};

  for (genvar p = 0; p < 3; p++) begin : g_rd
    assign w_rd[p] = (i_we && (w_ra[p] == i_wa)) ? i_wd : r_mem[w_ra[p]];
  end

  assign o_rd1 = w_rd[0];
  assign o_rd2 = w_rd[1];
  assign o_rd3 = w_rd[2];

endmodule

// File: rtl/decode_stage_pv.sv
// Scalar/vector decode stage: field decode, immediate extension, bypassed
// register reads and a valid/ready output register with load-use bubbles.
module decode_stage_pv
  import decode_pkg::*;
#(
  parameter  int DATA_W = 24,
  parameter  int LANES  = 6,
  parameter  int NREGS  = 16,
  parameter  int PC_W   = 24,
  localparam int VW     = LANES * DATA_W,
  localparam int RW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [PC_W-1:0]   pc,
  input  logic              we_s,
  input  logic              we_v,
  input  logic [RW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wd_s,
  input  logic [VW-1:0]     wd_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [11:0]       ex_ctrl,
  output logic [3:0]        ex_alu,
  output logic              ex_mode,
  output logic [RW-1:0]     ex_ra,
  output logic [RW-1:0]     ex_rb,
  output logic [RW-1:0]     ex_rc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_rd3,
  output logic [VW-1:0]     ex_rdv1,
  output logic [VW-1:0]     ex_rdv2,
  output logic [VW-1:0]     ex_rdv3,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PC_W-1:0]   ex_pc
);

  logic [1:0]              w_opt;
  logic [3:0]              w_opc;
  logic [RW-1:0]           w_ra, w_rb, w_rc;
  ctrl_t                   w_ctrl;
  logic [3:0]              w_alu;
  logic                    w_mode;
  logic [DATA_W-1:0]       w_imm;
  logic [2:0][DATA_W-1:0]  w_rd;
  logic [2:0][VW-1:0]      w_rv;
  logic                    w_uses_rc, w_hazard, w_accept;

  logic                    r_valid;
  ctrl_t                   r_ctrl;
  logic [3:0]              r_alu;
  logic                    r_mode;
  logic [RW-1:0]           r_ra, r_rb, r_rc;
  logic [2:0][DATA_W-1:0]  r_rd;
  logic [2:0][VW-1:0]      r_rv;
  logic [DATA_W-1:0]       r_imm;
  logic [PC_W-1:0]         r_pc;

  assign w_opt = inst[OPT_LSB +: 2];
  assign w_opc = inst[OPC_LSB +: FLD_W];
  assign w_rc  = RW'(inst[RC_LSB +: FLD_W]);
  assign w_ra  = RW'(inst[RA_LSB +: FLD_W]);
  assign w_rb  = RW'(inst[RB_LSB +: FLD_W]);

  always_comb begin
    w_ctrl        = '0;
    w_ctrl.optype = w_opt;
    w_ctrl.opcode = w_opc;
    w_alu         = '0;
    w_mode        = 1'b0;
    w_imm         = '0;
    case (optype_e'(w_opt))
      ALU: begin
        w_alu = w_opc;
        if (is_vec_op(w_opc)) begin
          w_ctrl.reg_write_v = 1'b1;
          w_mode             = 1'b1;
        end else begin
          w_ctrl.reg_write   = 1'b1;
        end
      end
      ALUI: begin
        w_ctrl.imm_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_alu            = w_opc;
        w_imm            = DATA_W'(inst[IMMI_W-1:0]);
      end
      MEM: begin
        w_alu = 4'b0001;
        if (w_opc == LD) begin
          w_ctrl.mem_to_reg = 1'b1;
          w_ctrl.reg_write  = 1'b1;
        end else if (w_opc == ST) begin
          w_ctrl.mem_write  = 1'b1;
        end
      end
      BR: begin
        w_ctrl.branch  = 1'b1;
        w_ctrl.imm_src = 1'b1;
        w_alu          = 4'b0001;
        w_imm          = DATA_W'(inst[IMMB_W-1:0]);
      end
    endcase
  end

  // Which source fields the incoming op actually consumes; stores also read Rc.
  always_comb begin
    w_uses_rc = 1'b0;
    case (optype_e'(w_opt))
      ALU:  w_uses_rc = (w_ra == r_rc) || (w_rb == r_rc);
      ALUI: w_uses_rc = (w_ra == r_rc);
      MEM:  w_uses_rc = (w_ra == r_rc) || (w_rb == r_rc) ||
                        ((w_opc == ST) && (w_rc == r_rc));
      BR:   w_uses_rc = 1'b0;
    endcase
  end

  assign w_hazard = in_valid && r_valid && r_ctrl.mem_to_reg && w_uses_rc;
  assign in_ready = (!r_valid || out_ready) && !w_hazard;
  assign w_accept = in_ready && in_valid && !flush;

  regfile_bypass #(.W(DATA_W), .NREGS(NREGS), .RW(RW)) u_rf_s (
    .i_clk(clk), .i_rst_n(rst), .i_we(we_s), .i_wa(wb_rd), .i_wd(wd_s),
    .i_ra1(w_ra), .i_ra2(w_rb), .i_ra3(w_rc),
    .o_rd1(w_rd[0]), .o_rd2(w_rd[1]), .o_rd3(w_rd[2])
  );

  regfile_bypass #(.W(VW), .NREGS(NREGS), .RW(RW)) u_rf_v (
    .i_clk(clk), .i_rst_n(rst), .i_we(we_v), .i_wa(wb_rd), .i_wd(wd_v),
    .i_ra1(w_ra), .i_ra2(w_rb), .i_ra3(w_rc),
    .o_rd1(w_rv[0]), .o_rd2(w_rv[1]), .o_rd3(w_rv[2])
  );

  // Payload only moves on acceptance; a stall or a drain leaves it in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_alu   <= '0;
      r_mode  <= 1'b0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_rd    <= '0;
      r_rv    <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
    end else begin
      r_valid <= w_accept || (!flush && r_valid && !out_ready);
      if (w_accept) begin
        r_ctrl <= w_ctrl;
        r_alu  <= w_alu;
        r_mode <= w_mode;
        r_ra   <= w_ra;
        r_rb   <= w_rb;
        r_rc   <= w_rc;
        r_rd   <= w_rd;
        r_rv   <= w_rv;
        r_imm  <= w_imm;
        r_pc   <= pc;
      end
    end
  end

  assign out_valid = r_valid;
  assign ex_ctrl   = r_ctrl;
  assign ex_alu    = r_alu;
  assign ex_mode   = r_mode;
  assign ex_ra     = r_ra;
  assign ex_rb     = r_rb;
  assign ex_rc     = r_rc;
  assign ex_rd1    = r_rd[0];
  assign ex_rd2    = r_rd[1];
  assign ex_rd3    = r_rd[2];
  assign ex_rdv1   = r_rv[0];
  assign ex_rdv2   = r_rv[1];
  assign ex_rdv3   = r_rv[2];
  assign ex_imm    = r_imm;
  assign ex_pc     = r_pc;

endmodule

// File: tb/tb_decode_stage_pv.sv
// Directed bench for decode_stage_pv: expected outputs are queued at issue
// and compared by a monitor on every output transfer.
module tb_decode_stage_pv;

  localparam int DW = 24;
  localparam int VW = 144;
  localparam logic [VW-1:0] V1 = 144'd981275;

  logic          clk, rst, flush, in_valid, in_ready, we_s, we_v;
  logic [31:0]   inst;
  logic [23:0]   pc;
  logic [3:0]    wb_rd;
  logic [DW-1:0] wd_s;
  logic [VW-1:0] wd_v;
  logic          out_valid, out_ready, ex_mode;
  logic [11:0]   ex_ctrl;
  logic [3:0]    ex_alu, ex_ra, ex_rb, ex_rc;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_rd3, ex_imm;
  logic [VW-1:0] ex_rdv1, ex_rdv2, ex_rdv3;
  logic [23:0]   ex_pc;

  typedef struct {
    logic [11:0]   ctrl;
    logic [3:0]    alu;
    logic          mode;
    logic [3:0]    ra, rb, rc;
    logic [DW-1:0] d1, d2, d3;
    logic [VW-1:0] v1, v2, v3;
    logic [DW-1:0] imm;
    logic [23:0]   pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_err = 0;

  decode_stage_pv dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .we_s(we_s), .we_v(we_v), .wb_rd(wb_rd), .wd_s(wd_s),
    .wd_v(wd_v), .out_valid(out_valid), .out_ready(out_ready), .ex_ctrl(ex_ctrl),
    .ex_alu(ex_alu), .ex_mode(ex_mode), .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rc(ex_rc),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rd3(ex_rd3), .ex_rdv1(ex_rdv1),
    .ex_rdv2(ex_rdv2), .ex_rdv3(ex_rdv3), .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] c, input logic [3:0] a, input logic m,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                              input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic [DW-1:0] d3, input logic [VW-1:0] v1,
                              input logic [VW-1:0] v2, input logic [VW-1:0] v3,
                              input logic [DW-1:0] imm, input logic [23:0] p);
    exp_t e;
    e.ctrl = c;  e.alu = a;  e.mode = m;
    e.ra = ra;   e.rb = rb;  e.rc = rc;
    e.d1 = d1;   e.d2 = d2;  e.d3 = d3;
    e.v1 = v1;   e.v2 = v2;  e.v3 = v3;
    e.imm = imm; e.pc = p;
    return e;
  endfunction

  // Monitor: every transfer to execute must match the oldest queued entry.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: got pc %0h, expected no transfer", ex_pc);
      end else begin
        m_e = exp_q.pop_front();
        chk("ex_ctrl", VW'(ex_ctrl), VW'(m_e.ctrl));
        chk("ex_alu",  VW'(ex_alu),  VW'(m_e.alu));
        chk("ex_mode", VW'(ex_mode), VW'(m_e.mode));
        chk("ex_ra",   VW'(ex_ra),   VW'(m_e.ra));
        chk("ex_rb",   VW'(ex_rb),   VW'(m_e.rb));
        chk("ex_rc",   VW'(ex_rc),   VW'(m_e.rc));
        chk("ex_rd1",  VW'(ex_rd1),  VW'(m_e.d1));
        chk("ex_rd2",  VW'(ex_rd2),  VW'(m_e.d2));
        chk("ex_rd3",  VW'(ex_rd3),  VW'(m_e.d3));
        chk("ex_rdv1", ex_rdv1,      m_e.v1);
        chk("ex_rdv2", ex_rdv2,      m_e.v2);
        chk("ex_rdv3", ex_rdv3,      m_e.v3);
        chk("ex_imm",  VW'(ex_imm),  VW'(m_e.imm));
        chk("ex_pc",   VW'(ex_pc),   VW'(m_e.pc));
      end
    end
  end

  task automatic wr_s(input logic [3:0] idx, input logic [DW-1:0] d);
    we_s = 1'b1; wb_rd = idx; wd_s = d;
    @(posedge clk); #1;
    we_s = 1'b0;
  endtask

  // Present an instruction until accepted (bounded), queueing its expectation.
  task automatic send(input logic [31:0] ins, input logic [23:0] p, input exp_t e);
    in_valid = 1'b1; inst = ins; pc = p;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    n_err++;
    $display("FAIL accept_timeout: got no acceptance of pc %0h, expected within 20 cycles", p);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; inst = '0; pc = '0;
    we_s = 1'b0; we_v = 1'b0; wb_rd = '0; wd_s = '0; wd_v = '0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", VW'(out_valid), '0);
    chk("rst_in_ready",  VW'(in_ready),  VW'(1'b1));
    chk("rst_ex_ctrl",   VW'(ex_ctrl),   '0);
    chk("rst_ex_rdv1",   ex_rdv1,        '0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // add r3,r1,r2 ; div r10,r6,#15 ; branch
    wr_s(4'd1, 24'd15);
    wr_s(4'd2, 24'd10);
    send(32'h00C48000, 24'h100, mk(12'h002, 4'h0, 1'b0, 4'd1, 4'd2, 4'd3, 24'd15, 24'd10, '0, '0, '0, '0, '0, 24'h100));
    send(32'h5698000F, 24'h104, mk(12'h562, 4'h5, 1'b0, 4'd6, 4'd0, 4'd10, '0, '0, '0, '0, '0, '0, 24'd15, 24'h104));
    send(32'hC00005DC, 24'h108, mk(12'hC30, 4'h1, 1'b0, 4'd0, 4'd0, 4'd0, '0, '0, '0, '0, '0, '0, 24'h5DC, 24'h108));

    // mulv r3,r1,r2 with same-cycle vector write of r1
    we_v = 1'b1; wb_rd = 4'd1; wd_v = V1;
    send(32'h38C48000, 24'h10C, mk(12'h381, 4'hE, 1'b1, 4'd1, 4'd2, 4'd3, 24'd15, 24'd10, '0, V1, '0, '0, '0, 24'h10C));
    we_v = 1'b0;

    // ld r15,[r0+r4] then add r1,r15,r2 which consumes r15 as Ra
    send(32'h83C10000, 24'h110, mk(12'h806, 4'h1, 1'b0, 4'd0, 4'd4, 4'd15, '0, '0, '0, '0, '0, '0, '0, 24'h110));
    in_valid = 1'b1; inst = 32'h007C8000; pc = 24'h114;
    @(negedge clk);
    chk("lu_in_ready_stall", VW'(in_ready), '0);
    chk("lu_out_valid_ld",   VW'(out_valid), VW'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("lu_bubble_out_valid", VW'(out_valid), '0);
    chk("lu_in_ready_free",    VW'(in_ready),  VW'(1'b1));
    exp_q.push_back(mk(12'h002, 4'h0, 1'b0, 4'd15, 4'd2, 4'd1, '0, 24'd10, 24'd15, '0, '0, V1, '0, 24'h114));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // sub r5,r1,r2 held 3 cycles while st waits behind it
    send(32'h05448000, 24'h118, mk(12'h042, 4'h1, 1'b0, 4'd1, 4'd2, 4'd5, 24'd15, 24'd10, '0, V1, '0, '0, '0, 24'h118));
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h84840000; pc = 24'h11C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  VW'(in_ready),  '0);
      chk("stall_out_valid", VW'(out_valid), VW'(1'b1));
      chk("stall_ex_pc",     VW'(ex_pc),     VW'(24'h118));
      chk("stall_ex_ctrl",   VW'(ex_ctrl),   VW'(12'h042));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", VW'(in_ready), VW'(1'b1));
    exp_q.push_back(mk(12'h848, 4'h1, 1'b0, 4'd1, 4'd0, 4'd2, 24'd15, '0, 24'd10, V1, '0, '0, '0, 24'h11C));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("no_dup_out_valid", VW'(out_valid), '0);
    @(posedge clk); #1;

    // flush kills the held op and the incoming one; the r7 write still lands
    send(32'h5698000F, 24'h120, mk(12'h562, 4'h5, 1'b0, 4'd6, 4'd0, 4'd10, '0, '0, '0, '0, '0, '0, 24'd15, 24'h120));
    out_ready = 1'b0;
    void'(exp_q.pop_back());
    flush = 1'b1; in_valid = 1'b1; inst = 32'h00C48000; pc = 24'h124;
    we_s = 1'b1; wb_rd = 4'd7; wd_s = 24'h77;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; we_s = 1'b0;
    chk("flush_out_valid", VW'(out_valid), '0);
    chk("flush_in_ready",  VW'(in_ready),  VW'(1'b1));
    out_ready = 1'b1;
    send(32'h021C4000, 24'h128, mk(12'h002, 4'h0, 1'b0, 4'd7, 4'd1, 4'd8, 24'h77, 24'd15, '0, '0, V1, '0, '0, 24'h128));

    // async reset while a branch is stalled in the output register
    send(32'hC00005DC, 24'h12C, mk(12'hC30, 4'h1, 1'b0, 4'd0, 4'd0, 4'd0, '0, '0, '0, '0, '0, '0, 24'h5DC, 24'h12C));
    out_ready = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", VW'(out_valid), '0);
    chk("arst_ex_ctrl",   VW'(ex_ctrl),   '0);
    chk("arst_ex_alu",    VW'(ex_alu),    '0);
    chk("arst_ex_imm",    VW'(ex_imm),    '0);
    chk("arst_ex_pc",     VW'(ex_pc),     '0);
    chk("arst_ex_rd1",    VW'(ex_rd1),    '0);
    chk("arst_in_ready",  VW'(in_ready),  VW'(1'b1));
    #2 rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h00C48000, 24'h130, mk(12'h002, 4'h0, 1'b0, 4'd1, 4'd2, 4'd3, '0, '0, '0, '0, '0, '0, '0, 24'h130));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("queue_drained", VW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
